// File: rtl/matrix_skew_feeder.sv
// Snapshots an NxN operand matrix on start and streams N diagonally skewed
// (2N-1)-lane beats toward a systolic array edge over an out_valid/out_ready handshake.
module matrix_skew_feeder #(
  parameter int unsigned N          = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  row_sel,
  input  logic [DATA_WIDTH-1:0] matrix         [0:N-1][0:N-1],
  input  logic                  valid_bits_in  [0:N-1][0:N-1],
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data       [0:2*N-2],
  output logic                  valid_bits_out [0:2*N-2],
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic [$clog2(N)-1:0]  beat_idx
);

  localparam int unsigned L         = 2 * N - 1;
  localparam int unsigned BW        = $clog2(N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           beat_d;
  logic [DATA_WIDTH-1:0]   snap_data_q  [0:N-1][0:N-1];
  logic [DATA_WIDTH-1:0]   snap_data_d  [0:N-1][0:N-1];
  logic                    snap_valid_q [0:N-1][0:N-1];
  logic                    snap_valid_d [0:N-1][0:N-1];
  logic                    snap_row_q, snap_row_d;
  logic [DATA_WIDTH-1:0]   data_d       [0:L-1];
  logic                    vbits_d      [0:L-1];
  logic                    out_valid_d, busy_d, done_d;
  logic                    load_beat;

  logic [DATA_WIDTH-1:0]   lane_data    [0:L-1];
  logic                    lane_valid   [0:L-1];
  logic [BW-1:0]           build_k;
  logic                    build_row;
  logic [DATA_WIDTH-1:0]   elem;
  logic                    elem_v;

  // Builds the next beat to present: beat 0 straight from the inputs while
  // idle (snapshot not loaded yet), otherwise the following beat from the snapshot.
  always_comb begin
    if (state_q == S_IDLE) begin
      build_k = '0;
    end else if (beat_idx == LAST_BEAT) begin
      build_k = beat_idx;
    end else begin
      build_k = beat_idx + BW'(1);
    end
    build_row = (state_q == S_IDLE) ? row_sel : snap_row_q;
    elem      = '0;
    elem_v    = 1'b0;
    for (int l = 0; l < int'(L); l++) begin
      lane_data[l]  = '0;
      lane_valid[l] = 1'b1;
    end
    for (int j = 0; j < int'(N); j++) begin
      if (state_q == S_IDLE) begin
        elem   = build_row ? matrix[build_k][j]        : matrix[j][build_k];
        elem_v = build_row ? valid_bits_in[build_k][j] : valid_bits_in[j][build_k];
      end else begin
        elem   = build_row ? snap_data_q[build_k][j]  : snap_data_q[j][build_k];
        elem_v = build_row ? snap_valid_q[build_k][j] : snap_valid_q[j][build_k];
      end
      for (int l = 0; l < int'(L); l++) begin
        if (l == int'(build_k) + j) begin
          lane_data[l]  = elem;
          lane_valid[l] = elem_v;
        end
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_idx;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    snap_row_d   = snap_row_q;
    data_d       = out_data;
    vbits_d      = valid_bits_out;
    out_valid_d  = out_valid;
    busy_d       = busy;
    done_d       = 1'b0;
    load_beat    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_data_d  = matrix;
          snap_valid_d = valid_bits_in;
          snap_row_d   = row_sel;
          beat_d       = '0;
          out_valid_d  = 1'b1;
          busy_d       = 1'b1;
          load_beat    = 1'b1;
          state_d      = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (beat_idx == LAST_BEAT) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
            for (int l = 0; l < int'(L); l++) begin
              data_d[l]  = '0;
              vbits_d[l] = 1'b0;
            end
          end else begin
            beat_d    = beat_idx + BW'(1);
            load_beat = 1'b1;
          end
        end
      end
      S_DONE: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        beat_d      = '0;
        state_d     = S_IDLE;
        for (int l = 0; l < int'(L); l++) begin
          data_d[l]  = '0;
          vbits_d[l] = 1'b0;
        end
      end
      default: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        beat_d      = '0;
        state_d     = S_IDLE;
      end
    endcase

    if (load_beat) begin
      data_d  = lane_data;
      vbits_d = lane_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_idx   <= '0;
      snap_row_q <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          snap_data_q[i][j]  <= '0;
          snap_valid_q[i][j] <= 1'b0;
        end
      end
      for (int l = 0; l < int'(L); l++) begin
        out_data[l]       <= '0;
        valid_bits_out[l] <= 1'b0;
      end
    end else begin
      state_q        <= state_d;
      beat_idx       <= beat_d;
      snap_row_q     <= snap_row_d;
      out_valid      <= out_valid_d;
      busy           <= busy_d;
      done           <= done_d;
      snap_data_q    <= snap_data_d;
      snap_valid_q   <= snap_valid_d;
      out_data       <= data_d;
      valid_bits_out <= vbits_d;
    end
  end

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// Randomized self-checking bench for matrix_skew_feeder (N=3 and N=4 instances)
// against a lane-arithmetic reference of the skew pattern.
module tb_matrix_skew_feeder;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n;

  logic          start3, row3, rdy3;
  logic [DW-1:0] m3  [0:2][0:2];
  logic          v3  [0:2][0:2];
  logic [DW-1:0] od3 [0:4];
  logic          vo3 [0:4];
  logic          ov3, busy3, done3;
  logic [1:0]    bidx3;

  logic          start4, row4, rdy4;
  logic [DW-1:0] m4  [0:3][0:3];
  logic          v4  [0:3][0:3];
  logic [DW-1:0] od4 [0:6];
  logic          vo4 [0:6];
  logic          ov4, busy4, done4;
  logic [1:0]    bidx4;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mm [0:3][0:3];
  logic       mv [0:3][0:3];
  logic       mrow;

  always #5 clk = ~clk;

  matrix_skew_feeder #(.N(3), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .row_sel(row3),
    .matrix(m3), .valid_bits_in(v3), .out_ready(rdy3),
    .out_data(od3), .valid_bits_out(vo3), .out_valid(ov3),
    .busy(busy3), .done(done3), .beat_idx(bidx3)
  );

  matrix_skew_feeder #(.N(4), .DATA_WIDTH(DW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .row_sel(row4),
    .matrix(m4), .valid_bits_in(v4), .out_ready(rdy4),
    .out_data(od4), .valid_bits_out(vo4), .out_valid(ov4),
    .busy(busy4), .done(done4), .beat_idx(bidx4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference beat k of an n x n transfer: lane l holds element j=l-k when in range, else valid zero pad.
  function automatic logic [63:0] exp_data(input int n, input int k);
    logic [63:0] r = '0;
    for (int l = 0; l < 2 * n - 1; l++) begin
      int j = l - k;
      if (j >= 0 && j < n) r[l*8 +: 8] = mrow ? mm[k][j] : mm[j][k];
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_valid(input int n, input int k);
    logic [63:0] r = '0;
    for (int l = 0; l < 2 * n - 1; l++) begin
      int j = l - k;
      if (j >= 0 && j < n) r[l] = mrow ? mv[k][j] : mv[j][k];
      else                 r[l] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [63:0] pk3d();
    logic [63:0] r = '0;
    for (int l = 0; l < 5; l++) r[l*8 +: 8] = od3[l];
    return r;
  endfunction

  function automatic logic [63:0] pk3v();
    logic [63:0] r = '0;
    for (int l = 0; l < 5; l++) r[l] = vo3[l];
    return r;
  endfunction

  function automatic logic [63:0] pk4d();
    logic [63:0] r = '0;
    for (int l = 0; l < 7; l++) r[l*8 +: 8] = od4[l];
    return r;
  endfunction

  function automatic logic [63:0] pk4v();
    logic [63:0] r = '0;
    for (int l = 0; l < 7; l++) r[l] = vo4[l];
    return r;
  endfunction

  task automatic rand3();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        m3[i][j] = 8'($urandom);
        v3[i][j] = 1'($urandom);
      end
    row3 = 1'($urandom);
  endtask

  task automatic capture3();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        mm[i][j] = m3[i][j];
        mv[i][j] = v3[i][j];
      end
    mrow = row3;
  endtask

  // mode 0: always ready, 1: random stalls, 2: two stall cycles on beat 1.
  // noise: scramble inputs and toggle start while the transfer is in flight.
  task automatic xfer3(input int mode, input bit noise);
    int k, cyc, stalls, s1;
    capture3();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    if (noise) rand3();
    k = 0; cyc = 0; stalls = 0; s1 = 0;
    while (k < 3 && cyc < 40) begin
      chk($sformatf("n3_valid_b%0d", k), 64'(ov3), 64'd1);
      chk($sformatf("n3_busy_b%0d", k), 64'(busy3), 64'd1);
      chk($sformatf("n3_done_b%0d", k), 64'(done3), 64'd0);
      chk($sformatf("n3_idx_b%0d", k), 64'(bidx3), 64'(k));
      chk($sformatf("n3_data_b%0d", k), pk3d(), exp_data(3, k));
      chk($sformatf("n3_vbits_b%0d", k), pk3v(), exp_valid(3, k));
      case (mode)
        0:       rdy3 = 1'b1;
        1:       rdy3 = ($urandom_range(0, 2) != 0);
        default: rdy3 = !(k == 1 && s1 < 2);
      endcase
      if (k == 1 && !rdy3) s1++;
      if (noise) begin
        start3 = 1'($urandom);
        rand3();
      end
      tick();
      cyc++;
      if (rdy3) k++;
      else      stalls++;
    end
    start3 = 1'b0;
    chk("n3_beats_done", 64'(k), 64'd3);
    chk("n3_beat_cycles", 64'(cyc), 64'(3 + stalls));
    if (mode == 2) chk("n3_stall_cycles", 64'(cyc), 64'd5);
    chk("n3_done_pulse", 64'(done3), 64'd1);
    chk("n3_done_ovalid", 64'(ov3), 64'd0);
    chk("n3_done_busy", 64'(busy3), 64'd1);
    chk("n3_done_data", pk3d(), 64'd0);
    chk("n3_done_vbits", pk3v(), 64'd0);
    rdy3 = 1'($urandom);
    tick();
    chk("n3_idle_done", 64'(done3), 64'd0);
    chk("n3_idle_busy", 64'(busy3), 64'd0);
    chk("n3_idle_ovalid", 64'(ov3), 64'd0);
    rdy3 = 1'b0;
  endtask

  task automatic xfer4();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mm[i][j] = m4[i][j];
        mv[i][j] = v4[i][j];
      end
    mrow   = row4;
    start4 = 1'b1;
    rdy4   = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("n4_valid_b%0d", k), 64'(ov4), 64'd1);
      chk($sformatf("n4_idx_b%0d", k), 64'(bidx4), 64'(k));
      chk($sformatf("n4_data_b%0d", k), pk4d(), exp_data(4, k));
      chk($sformatf("n4_vbits_b%0d", k), pk4v(), exp_valid(4, k));
      tick();
    end
    chk("n4_done_pulse", 64'(done4), 64'd1);
    chk("n4_done_ovalid", 64'(ov4), 64'd0);
    tick();
    chk("n4_idle_busy", 64'(busy4), 64'd0);
    chk("n4_idle_done", 64'(done4), 64'd0);
    rdy4 = 1'b0;
  endtask

  task automatic chk_reset3(input string tag);
    chk({tag, "_ovalid"}, 64'(ov3), 64'd0);
    chk({tag, "_busy"}, 64'(busy3), 64'd0);
    chk({tag, "_done"}, 64'(done3), 64'd0);
    chk({tag, "_idx"}, 64'(bidx3), 64'd0);
    chk({tag, "_data"}, pk3d(), 64'd0);
    chk({tag, "_vbits"}, pk3v(), 64'd0);
  endtask

  initial begin
    rst_n  = 1'b1;
    start3 = 1'b0; row3 = 1'b0; rdy3 = 1'b0;
    start4 = 1'b0; row4 = 1'b0; rdy4 = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        m3[i][j] = '0;
        v3[i][j] = 1'b0;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        m4[i][j] = '0;
        v4[i][j] = 1'b0;
      end
    #2 rst_n = 1'b0;
    #1;
    chk_reset3("rst");
    chk("rst_n4_ovalid", 64'(ov4), 64'd0);
    chk("rst_n4_data", pk4d(), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Matrix 1..9 row-major, all valid: row mode then column mode.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        m3[i][j] = 8'(3 * i + j + 1);
        v3[i][j] = 1'b1;
      end
    row3 = 1'b1;
    xfer3(0, 1'b0);
    row3 = 1'b0;
    xfer3(0, 1'b0);

    // One invalid element in the middle.
    row3 = 1'b1;
    v3[1][1] = 1'b0;
    xfer3(0, 1'b0);
    v3[1][1] = 1'b1;

    // Two-cycle stall on beat 1.
    xfer3(2, 1'b0);

    // start and inputs churn during EMIT; the next transfer picks up the new values.
    rand3();
    xfer3(0, 1'b1);
    xfer3(0, 1'b0);

    // Asynchronous reset during beat 2.
    rand3();
    capture3();
    start3 = 1'b1;
    rdy3   = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    tick();
    chk("abort_pre_idx", 64'(bidx3), 64'd2);
    chk("abort_pre_data", pk3d(), exp_data(3, 2));
    #2 rst_n = 1'b0;
    #1;
    chk_reset3("abort");
    tick();
    rst_n = 1'b1;
    rdy3  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("abort_no_done_c%0d", c), 64'(done3), 64'd0);
      chk($sformatf("abort_idle_c%0d", c), 64'(ov3), 64'd0);
    end
    rdy3 = 1'b0;
    rand3();
    xfer3(0, 1'b0);

    // Randomized transfers with random back-pressure.
    for (int t = 0; t < 20; t++) begin
      rand3();
      xfer3(1, 1'($urandom));
    end

    // N=4: directed row mode with all valid, then random transfers.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        m4[i][j] = 8'(16 * i + j + 1);
        v4[i][j] = 1'b1;
      end
    row4 = 1'b1;
    xfer4();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          m4[i][j] = 8'($urandom);
          v4[i][j] = 1'($urandom);
        end
      row4 = 1'($urandom);
      xfer4();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/matrix_skew_feeder.md
# matrix_skew_feeder

Parametrised successor to the fixed 3x3 row/column skewer: snapshots an NxN matrix and its per-element valid bits on a start pulse, then emits N diagonally skewed beats of width 2N-1 over an out_valid/out_ready handshake. Row mode feeds matrix rows and column mode feeds matrix columns. The block sits between the operand buffer and the systolic array edge. It adds stall tolerance, start/busy/done control and input decoupling.

## Interface
- N, default 3: matrix dimension; legal N >= 2.
- DATA_WIDTH, default 8: element width in bits.
- L (localparam) = 2N-1: output lane count.

- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a new transfer; honoured only in IDLE.
- row_sel  input  1  mode, sampled with start: 1 = row mode, 0 = column mode.
- matrix  input  DATA_WIDTH x [0:N-1][0:N-1]  operand matrix, sampled with start.
- valid_bits_in  input  1 x [0:N-1][0:N-1]  per-element valid, sampled with start.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  DATA_WIDTH x [0:L-1]  skewed beat.
- valid_bits_out  output  1 x [0:L-1]  per-lane valid.
- out_valid  output  1  beat present on out_data.
- busy  output  1  high in EMIT and DONE.
- done  output  1  one-cycle pulse after the last beat is accepted.
- beat_idx  output  $clog2(N) bits  index of the beat currently presented.

## Operation
- States: IDLE, then EMIT, then DONE, then IDLE.
- IDLE, start=1: capture matrix, valid_bits_in and row_sel into internal snapshot registers. Set beat_idx=0 and go to EMIT. Inputs are don't-care from the next cycle on.
- Element e(k,j): row mode uses snap[k][j]; column mode uses snap[j][k]. Element valid v(k,j) follows the same indexing.
- Beat k, for k = 0..N-1:
  - out_data[k+j] = e(k,j) and valid_bits_out[k+j] = v(k,j), for j = 0..N-1.
  - All other lanes carry 0 with valid_bits_out = 1. Zero padding counts as valid data.
- EMIT:
  - out_valid=1.
  - out_valid && out_ready with beat_idx < N-1: advance beat_idx.
  - out_valid && out_ready with beat_idx == N-1: go to DONE.
  - out_ready=0: out_data, valid_bits_out and beat_idx hold unchanged.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored and does not change the snapshot or mode.
- Whenever out_valid=0, out_data and valid_bits_out are all zero.

## Timing
- Reset values:
  - state IDLE.
  - out_data all 0.
  - valid_bits_out all 0.
  - out_valid 0, busy 0, done 0, beat_idx 0.
  - Snapshot registers 0.
- Reset asserted mid-transfer aborts the transfer immediately, asynchronously. No done pulse is issued.
- Outputs are registered. With start sampled at edge t:
  - beat 0 is valid after edge t, with busy=1 in the same cycle.
- Zero-stall transfer (out_ready held 1):
  - beats occupy cycles t+1..t+N.
  - done is high in cycle t+N+1.
  - IDLE from cycle t+N+2, so the earliest next start is sampled at edge t+N+2.
- Each stall cycle extends the transfer by exactly one cycle.
- out_valid never drops while a beat is unaccepted.
- Beat order is strictly 0..N-1, with no skipped or repeated beats.
- beat_idx wraps only through DONE/IDLE, never in place.

## Test plan
- N=3, matrix 1..9 row-major, all valid, row_sel=1, out_ready=1. Required beats:
  - [1,2,3,0,0], [0,4,5,6,0], [0,0,7,8,9].
  - valid_bits_out all 1 on every beat.
  - done on the 4th cycle after start.
- Same matrix, row_sel=0. Required beats:
  - [1,4,7,0,0], [0,2,5,8,0], [0,0,3,6,9].
- Row mode, valid_bits_in[1][1]=0, remainder 1:
  - beat 1 valid_bits_out = [1,1,0,1,1].
  - the other beats have all lanes valid.
- out_ready low for 2 cycles during beat 1, then high:
  - beat 1 is held stable for 3 cycles.
  - total transfer is 5 beat-cycles.
  - one done pulse.
- start re-asserted during EMIT with a changed matrix and row_sel:
  - output is unaffected.
  - a subsequent start in IDLE uses the new values.
- rst_n pulsed low during beat 2:
  - all outputs return to reset values asynchronously.
  - no done pulse.
  - normal transfer follows the next start.
- N=4 row mode, 7-lane beats: beat 3 = [0,0,0,m30,m31,m32,m33].
